// File: rtl/pipeline_stages_valid_ready.sv
// STAGES-deep valid/ready register pipeline; each stage adds INC (mod 2^WIDTH), with bubble collapsing and flush.
// Optional occupancy output when PIPE_OCCUPANCY_EN is defined.
module pipeline_stages_valid_ready #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int INC    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PIPE_OCCUPANCY_EN
    ,
    output logic [$clog2(STAGES+1)-1:0] occupancy
`endif
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [WIDTH-1:0]  d_d [STAGES];
    logic [STAGES:0]   r;
    logic [STAGES-1:0] src_v;
    logic [WIDTH-1:0]  src_d [STAGES];

    // Each stage is fed either by the producer or by its upstream neighbour.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign src_v[gi] = in_valid;
                assign src_d[gi] = in_data;
            end else begin : g_link
                assign src_v[gi] = v_q[gi-1];
                assign src_d[gi] = d_q[gi-1];
            end
        end
    endgenerate

    // A stage can take a beat if it is empty or its own beat moves on this cycle.
    always_comb begin
        r         = '0;
        r[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r[k] = ~v_q[k] | r[k+1];
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (r[k]) begin
                    v_d[k] = src_v[k];
                    if (src_v[k]) begin
                        d_d[k] = src_d[k] + INC_W;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign in_ready  = r[0] & ~flush;
    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];

`ifdef PIPE_OCCUPANCY_EN
    localparam int OCC_W = $clog2(STAGES + 1);

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy = occupancy + OCC_W'(v_q[k]);
        end
    end
`endif

endmodule
